// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
package uart_cmd_pkg;

    // Parser states: hunt for SYNC, collect the frame, then hold the result
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        HOLD    = 3'd5
    } state_t;

    // Error codes reported on o_err_code
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // True while a frame is partially received (the inter-byte timer runs here)
    function automatic logic frame_active(input state_t s);
        return (s == CMD) || (s == LEN) || (s == PAYLOAD) || (s == CHK);
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Clear-and-count idle timer. Counts clocks while run_i is high and no clear
// arrives; tc_o pulses on the cycle the count sits at COUNT-1 without a clear,
// and the count restarts from zero after that pulse.
module uart_cmd_timer #(
    parameter int COUNT = 20840
) (
    input  logic i_Clock,
    input  logic i_rst,
    input  logic run_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A clear on the terminal cycle suppresses the pulse: the byte wins
    assign tc_o = run_i && !clr_i && (count_q == CNT_W'(COUNT - 1));

    // Next count: hold at zero when stopped, cleared, or after terminal count
    always_comb begin
        count_d = count_q + 1'b1;
        if (!run_i || clr_i || tc_o) begin
            count_d = '0;
        end
    end

    // Count register
    always_ff @(posedge i_Clock) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command parser sitting behind the UART receiver.
// Frame: SYNC, CMD, LEN, LEN payload bytes, XOR checksum over CMD/LEN/payload.
// A validated command is held on o_cmd/o_len/o_payload with o_cmd_valid until
// i_cmd_ready. Build option: define UART_CMD_TIMEOUT_EN to enable the
// inter-byte timeout (error code 3); without it the parser waits indefinitely.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN      = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 20840
) (
    input  logic                 i_Clock,
    input  logic                 i_rst,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    input  logic                 i_cmd_ready,
    output logic                 o_cmd_valid,
    output logic [7:0]           o_cmd,
    output logic [4:0]           o_len,
    output logic [8*MAX_LEN-1:0] o_payload,
    output logic                 o_err,
    output logic [1:0]           o_err_code,
    output logic                 o_overrun
);

    localparam int IDX_W = 5;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [4:0]       len_q, len_d;
    logic [7:0]       csum_q, csum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             overrun_q, overrun_d;
    logic             pay_clr;
    logic             pay_wr;
    logic             timeout;

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timer #(
        .COUNT (TIMEOUT_CLKS)
    ) u_timer (
        .i_Clock (i_Clock),
        .i_rst   (i_rst),
        .run_i   (frame_active(state_q)),
        .clr_i   (i_Rx_DV),
        .tc_o    (timeout)
    );
`else
    logic unused_timeout_clks;
    assign unused_timeout_clks = ^TIMEOUT_CLKS;
    assign timeout             = 1'b0;
`endif

    // Next-state and datapath decisions; one byte consumed per strobe
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        csum_d     = csum_q;
        idx_d      = idx_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        overrun_d  = 1'b0;
        pay_clr    = 1'b0;
        pay_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    pay_clr = 1'b1;
                    csum_d  = '0;
                    idx_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (i_Rx_DV) begin
                    cmd_d   = i_Rx_Byte;
                    csum_d  = i_Rx_Byte;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte > 8'(MAX_LEN)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = IDLE;
                    end else begin
                        len_d  = i_Rx_Byte[4:0];
                        csum_d = csum_q ^ i_Rx_Byte;
                        if (i_Rx_Byte == 8'd0) begin
                            state_d = CHK;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (i_Rx_DV) begin
                    pay_wr = 1'b1;
                    csum_d = csum_q ^ i_Rx_Byte;
                    idx_d  = idx_q + 1'b1;
                    if ((idx_q + 1'b1) == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == csum_q) begin
                        state_d = HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = IDLE;
                    end
                end
            end
            HOLD: begin
                // Result must stay stable, so any byte here is dropped
                if (i_Rx_DV) begin
                    overrun_d = 1'b1;
                end
                if (i_cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer only fires mid-frame and never on a byte cycle
        if (timeout) begin
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
            state_d    = IDLE;
        end
    end

    // Control and header registers
    always_ff @(posedge i_Clock) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            overrun_q  <= overrun_d;
        end
    end

    // Payload bytes are read in parallel, so each lives in its own register
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_payload
        logic [7:0] byte_q;

        // Cleared on SYNC so bytes beyond the length read as zero
        always_ff @(posedge i_Clock) begin
            if (i_rst || pay_clr) begin
                byte_q <= '0;
            end else if (pay_wr && (idx_q == IDX_W'(gi))) begin
                byte_q <= i_Rx_Byte;
            end
        end

        assign o_payload[8*gi +: 8] = byte_q;
    end

    assign o_cmd_valid = (state_q == HOLD);
    assign o_cmd       = cmd_q;
    assign o_len       = len_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_overrun   = overrun_q;

endmodule
